// File: rtl/pipe_fetch_dreg_pkg.sv
// rtl/pipe_fetch_dreg_pkg.sv - shared Y86-64 encodings and pipeline-register bubble values
package pipe_fetch_dreg_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Register id meaning "no register"
    localparam logic [3:0] R_NONE = 4'hF;

    // Status codes
    localparam logic [3:0] STAT_AOK = 4'h1;
    localparam logic [3:0] STAT_HLT = 4'h2;
    localparam logic [3:0] STAT_ADR = 4'h3;
    localparam logic [3:0] STAT_INS = 4'h4;

    // Narrow fields shared by every pipeline register bank
    typedef struct packed {
        logic [3:0] stat;
        logic [3:0] icode;
        logic [3:0] ifun;
        logic [3:0] ra;
        logic [3:0] rb;
    } stage_hdr_t;

    // Bubble contents: a NOP with no register operands; wide fields clear to zero
    localparam stage_hdr_t BUBBLE_HDR = '{
        stat:  STAT_AOK,
        icode: I_NOP,
        ifun:  4'h0,
        ra:    R_NONE,
        rb:    R_NONE
    };

    // Instructions whose next PC is predicted to be their constant word
    function automatic logic predicts_valc(input logic [3:0] icode);
        return (icode == I_JXX) || (icode == I_CALL);
    endfunction

endpackage

// File: rtl/pipe_fetch_dreg_if.sv
// rtl/pipe_fetch_dreg_if.sv - fetch/decode boundary bus with control, M/W feedback and D outputs
interface pipe_fetch_dreg_if #(
    parameter int PC_W  = 64,
    parameter int CNT_W = 32
);
    // Control unit
    logic              F_stall;
    logic              D_stall;
    logic              D_bubble;
    // Later-stage feedback for PC selection
    logic [3:0]        M_icode;
    logic              M_cnd;
    logic [PC_W-1:0]   M_valA;
    logic [3:0]        W_icode;
    logic [PC_W-1:0]   W_valM;
    // Fetch aligner fields
    logic [3:0]        f_icode;
    logic [3:0]        f_ifun;
    logic [3:0]        f_rA;
    logic [3:0]        f_rB;
    logic [PC_W-1:0]   f_valC;
    logic [PC_W-1:0]   f_valP;
    logic [3:0]        f_stat;
    // Outputs
    logic [PC_W-1:0]   f_pc;
    logic [PC_W-1:0]   F_predPC;
    logic [3:0]        D_stat;
    logic [3:0]        D_icode;
    logic [3:0]        D_ifun;
    logic [3:0]        D_rA;
    logic [3:0]        D_rB;
    logic [PC_W-1:0]   D_valC;
    logic [PC_W-1:0]   D_valP;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    modport slave (
        input  F_stall, D_stall, D_bubble,
        input  M_icode, M_cnd, M_valA, W_icode, W_valM,
        input  f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat,
        output f_pc, F_predPC,
        output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        output stall_cnt, bubble_cnt
    );

    modport master (
        output F_stall, D_stall, D_bubble,
        output M_icode, M_cnd, M_valA, W_icode, W_valM,
        output f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat,
        input  f_pc, F_predPC,
        input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        input  stall_cnt, bubble_cnt
    );

endinterface

// File: rtl/pipe_fetch_dreg_sat_counter.sv
// rtl/pipe_fetch_dreg_sat_counter.sv - saturating event counter
module pipe_fetch_dreg_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Count enabled cycles, sticking at all-ones instead of wrapping
    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_fetch_dreg.sv
// rtl/pipe_fetch_dreg.sv - Y86-64 F register, PC select/predict and F/D pipeline register
module pipe_fetch_dreg
    import pipe_fetch_dreg_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    pipe_fetch_dreg_if.slave      bus
);

    logic [PC_W-1:0] pred_pc_q;
    logic [PC_W-1:0] pred_pc_d;
    logic [PC_W-1:0] f_pred_pc;
    logic [PC_W-1:0] f_pc_sel;

    stage_hdr_t      d_hdr_q;
    stage_hdr_t      d_hdr_d;
    logic [PC_W-1:0] d_valc_q;
    logic [PC_W-1:0] d_valc_d;
    logic [PC_W-1:0] d_valp_q;
    logic [PC_W-1:0] d_valp_d;

    // Select this cycle's fetch address: mispredicted branch beats a returning ret
    always_comb begin
        f_pc_sel = pred_pc_q;
        if ((bus.M_icode == I_JXX) && !bus.M_cnd) begin
            f_pc_sel = bus.M_valA;
        end else if (bus.W_icode == I_RET) begin
            f_pc_sel = bus.W_valM;
        end
    end

    // Predict the next PC: jumps and calls are assumed taken
    always_comb begin
        f_pred_pc = bus.f_valP;
        if (predicts_valc(bus.f_icode)) begin
            f_pred_pc = bus.f_valC;
        end
    end

    // F register next state: hold on stall, otherwise take the prediction
    always_comb begin
        pred_pc_d = f_pred_pc;
        if (bus.F_stall) begin
            pred_pc_d = pred_pc_q;
        end
    end

    // F register
    always_ff @(posedge clk) begin
        if (reset) begin
            pred_pc_q <= RESET_PC;
        end else begin
            pred_pc_q <= pred_pc_d;
        end
    end

    // D register next state: stall outranks bubble, bubble outranks normal capture
    always_comb begin
        d_hdr_d.stat  = bus.f_stat;
        d_hdr_d.icode = bus.f_icode;
        d_hdr_d.ifun  = bus.f_ifun;
        d_hdr_d.ra    = bus.f_rA;
        d_hdr_d.rb    = bus.f_rB;
        d_valc_d      = bus.f_valC;
        d_valp_d      = bus.f_valP;
        if (bus.D_stall) begin
            d_hdr_d  = d_hdr_q;
            d_valc_d = d_valc_q;
            d_valp_d = d_valp_q;
        end else if (bus.D_bubble) begin
            d_hdr_d  = BUBBLE_HDR;
            d_valc_d = '0;
            d_valp_d = '0;
        end
    end

    // D register; reset loads the bubble so decode sees a harmless NOP
    always_ff @(posedge clk) begin
        if (reset) begin
            d_hdr_q  <= BUBBLE_HDR;
            d_valc_q <= '0;
            d_valp_q <= '0;
        end else begin
            d_hdr_q  <= d_hdr_d;
            d_valc_q <= d_valc_d;
            d_valp_q <= d_valp_d;
        end
    end

    pipe_fetch_dreg_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (bus.F_stall),
        .count_o (bus.stall_cnt)
    );

    pipe_fetch_dreg_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (bus.D_bubble),
        .count_o (bus.bubble_cnt)
    );

    assign bus.f_pc     = f_pc_sel;
    assign bus.F_predPC = pred_pc_q;
    assign bus.D_stat   = d_hdr_q.stat;
    assign bus.D_icode  = d_hdr_q.icode;
    assign bus.D_ifun   = d_hdr_q.ifun;
    assign bus.D_rA     = d_hdr_q.ra;
    assign bus.D_rB     = d_hdr_q.rb;
    assign bus.D_valC   = d_valc_q;
    assign bus.D_valP   = d_valp_q;

endmodule

// File: tb/tb_pipe_fetch_dreg.sv
// tb/tb_pipe_fetch_dreg.sv - self-checking bench for pipe_fetch_dreg
module tb_pipe_fetch_dreg;

    localparam int PC_W  = 64;
    localparam int CNT_W = 3;
    localparam int CMAX  = 7;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pipe_fetch_dreg_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    pipe_fetch_dreg #(.PC_W(PC_W), .RESET_PC(64'h0), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state
    logic [63:0] m_pred;
    logic [3:0]  m_stat, m_icode, m_ifun, m_ra, m_rb;
    logic [63:0] m_valc, m_valp;
    int          m_stall_cnt, m_bubble_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_fpc();
        if (bus.M_icode == 4'd7 && bus.M_cnd == 1'b0) return bus.M_valA;
        if (bus.W_icode == 4'd9) return bus.W_valM;
        return m_pred;
    endfunction

    task automatic model_bubble();
        m_stat = 4'd1; m_icode = 4'd1; m_ifun = 4'd0; m_ra = 4'd15; m_rb = 4'd15;
        m_valc = 64'd0; m_valp = 64'd0;
    endtask

    // Advance one clock, apply the edge to the model, then compare every register
    task automatic step();
        @(posedge clk);
        if (reset) begin
            m_pred = 64'd0;
            model_bubble();
            m_stall_cnt = 0;
            m_bubble_cnt = 0;
        end else begin
            if (!bus.F_stall)
                m_pred = (bus.f_icode == 4'd7 || bus.f_icode == 4'd8) ? bus.f_valC : bus.f_valP;
            if (bus.D_stall) begin
            end else if (bus.D_bubble) begin
                model_bubble();
            end else begin
                m_stat = bus.f_stat; m_icode = bus.f_icode; m_ifun = bus.f_ifun;
                m_ra = bus.f_rA; m_rb = bus.f_rB; m_valc = bus.f_valC; m_valp = bus.f_valP;
            end
            if (bus.F_stall && m_stall_cnt < CMAX) m_stall_cnt++;
            if (bus.D_bubble && m_bubble_cnt < CMAX) m_bubble_cnt++;
        end
        #1;
        chk("F_predPC", bus.F_predPC, m_pred);
        chk("D_stat", {60'd0, bus.D_stat}, {60'd0, m_stat});
        chk("D_icode", {60'd0, bus.D_icode}, {60'd0, m_icode});
        chk("D_ifun", {60'd0, bus.D_ifun}, {60'd0, m_ifun});
        chk("D_rA", {60'd0, bus.D_rA}, {60'd0, m_ra});
        chk("D_rB", {60'd0, bus.D_rB}, {60'd0, m_rb});
        chk("D_valC", bus.D_valC, m_valc);
        chk("D_valP", bus.D_valP, m_valp);
        chk("stall_cnt", {61'd0, bus.stall_cnt}, 64'(m_stall_cnt));
        chk("bubble_cnt", {61'd0, bus.bubble_cnt}, 64'(m_bubble_cnt));
    endtask

    task automatic set_fetch(input logic [3:0] icode, input logic [3:0] ifun,
                             input logic [3:0] ra, input logic [3:0] rb,
                             input logic [63:0] valc, input logic [63:0] valp,
                             input logic [3:0] stat);
        bus.f_icode = icode; bus.f_ifun = ifun; bus.f_rA = ra; bus.f_rB = rb;
        bus.f_valC = valc; bus.f_valP = valp; bus.f_stat = stat;
    endtask

    task automatic set_ctrl(input logic fs, input logic ds, input logic db);
        bus.F_stall = fs; bus.D_stall = ds; bus.D_bubble = db;
    endtask

    task automatic set_mw(input logic [3:0] mi, input logic mc, input logic [63:0] ma,
                          input logic [3:0] wi, input logic [63:0] wm);
        bus.M_icode = mi; bus.M_cnd = mc; bus.M_valA = ma; bus.W_icode = wi; bus.W_valM = wm;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        m_pred = 64'd0;
        model_bubble();
        m_stall_cnt = 0;
        m_bubble_cnt = 0;

        // Reset then release
        reset = 1'b1;
        set_ctrl(1'b0, 1'b0, 1'b0);
        set_mw(4'd0, 1'b1, 64'd0, 4'd0, 64'd0);
        set_fetch(4'd6, 4'd0, 4'd1, 4'd2, 64'd0, 64'h2, 4'd1);
        step();
        chk("reset_predPC", bus.F_predPC, 64'h0);
        chk("reset_D_icode", {60'd0, bus.D_icode}, 64'd1);
        chk("reset_D_rA", {60'd0, bus.D_rA}, 64'd15);
        chk("reset_fpc", bus.f_pc, 64'h0);
        reset = 1'b0;
        step();
        chk("first_predPC", bus.F_predPC, 64'h2);
        chk("first_D_icode", {60'd0, bus.D_icode}, 64'd6);

        // jXX predicted taken, then a mispredict redirect from M
        set_fetch(4'd7, 4'd1, 4'd15, 4'd15, 64'h40, 64'h9, 4'd1);
        step();
        chk("jxx_predPC", bus.F_predPC, 64'h40);
        set_mw(4'd7, 1'b0, 64'h9, 4'd0, 64'd0);
        #1;
        chk("mispredict_fpc", bus.f_pc, 64'h9);
        chk("mispredict_predPC", bus.F_predPC, 64'h40);

        // ret redirect from W, then mispredict taking priority
        set_mw(4'd6, 1'b0, 64'h20, 4'd9, 64'h100);
        #1;
        chk("ret_fpc", bus.f_pc, 64'h100);
        set_mw(4'd7, 1'b0, 64'h20, 4'd9, 64'h100);
        #1;
        chk("priority_fpc", bus.f_pc, 64'h20);
        set_mw(4'd7, 1'b1, 64'h20, 4'd9, 64'h100);
        #1;
        chk("taken_ret_fpc", bus.f_pc, 64'h100);
        set_mw(4'd0, 1'b0, 64'd0, 4'd0, 64'd0);
        set_fetch(4'd3, 4'd0, 4'd15, 4'd4, 64'h1234, 64'h50, 4'd1);
        step();

        // Two-cycle stall of F and D with changing fetch fields
        set_ctrl(1'b1, 1'b1, 1'b0);
        set_fetch(4'd8, 4'd0, 4'd15, 4'd15, 64'h300, 64'h59, 4'd1);
        step();
        set_fetch(4'd5, 4'd0, 4'd7, 4'd3, 64'h8, 64'h63, 4'd3);
        step();
        chk("stall_hold_predPC", bus.F_predPC, 64'h50);
        chk("stall_hold_D_valC", bus.D_valC, 64'h1234);
        chk("stall_cnt_2", {61'd0, bus.stall_cnt}, 64'd2);

        // Bubble, then bubble with stall (stall wins)
        set_ctrl(1'b0, 1'b0, 1'b1);
        step();
        chk("bubble_D_icode", {60'd0, bus.D_icode}, 64'd1);
        chk("bubble_cnt_1", {61'd0, bus.bubble_cnt}, 64'd1);
        set_ctrl(1'b0, 1'b1, 1'b1);
        set_fetch(4'd6, 4'd2, 4'd1, 4'd2, 64'd0, 64'h70, 4'd1);
        step();
        chk("bubble_stall_D_icode", {60'd0, bus.D_icode}, 64'd1);
        chk("bubble_cnt_2", {61'd0, bus.bubble_cnt}, 64'd2);

        // Non-AOK status latched like any field
        set_ctrl(1'b0, 1'b0, 1'b0);
        set_fetch(4'd0, 4'd0, 4'd15, 4'd15, 64'd0, 64'h71, 4'd2);
        step();
        chk("hlt_D_stat", {60'd0, bus.D_stat}, 64'd2);

        // Drive stall_cnt to 6, then three more stall cycles saturate at 7
        set_ctrl(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk("stall_cnt_6", {61'd0, bus.stall_cnt}, 64'd6);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_cnt_sat", {61'd0, bus.stall_cnt}, 64'd7);
        end

        // Reset with stall and bubble pending
        set_ctrl(1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        step();
        chk("reset_mid_stall_cnt", {61'd0, bus.stall_cnt}, 64'd0);
        chk("reset_mid_D_icode", {60'd0, bus.D_icode}, 64'd1);
        reset = 1'b0;
        set_ctrl(1'b0, 1'b0, 1'b0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            set_ctrl($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
            set_mw(4'($urandom_range(5, 9)), 1'($urandom), {$urandom, $urandom},
                   4'($urandom_range(7, 10)), {$urandom, $urandom});
            set_fetch(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                      {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(1, 4)));
            #1;
            chk("rand_fpc", bus.f_pc, exp_fpc());
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
